operand_skew_feeder: RTL

Feeds one operand edge of the systolic array. It accepts ROWS operand rows of N elements each over a valid/ready handshake and emits them as N per-lane matrix_data_t streams. Lane i is delayed i cycles relative to lane 0, which produces the diagonal wavefront the PE grid needs, and the last flag rides on the final row. One instance sits between the operand memory reader and each array input edge (A rows, B columns).

---
 rtl/operand_skew_feeder_pkg.sv | 30 +++
 rtl/operand_skew_feeder_if.sv | 26 ++
 rtl/operand_skew_feeder_skew_delay_line.sv | 42 ++++
 rtl/operand_skew_feeder.sv | 113 +++++++++++
 4 files changed

// File: rtl/operand_skew_feeder_pkg.sv
// Shared types and sizing for the operand skew feeder that drives one systolic array edge.
package operand_skew_feeder_pkg;

  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  localparam int SYS_ARRAY_SIZE = 2;
  localparam int T_C            = 2;
  localparam int DATA_WIDTH     = 8;
  localparam int SKEW_DEPTH     = SYS_ARRAY_SIZE - 1;
  localparam int MCOUNT_W       = clog2_min1(T_C);

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [MCOUNT_W-1:0]   mcount_t;

  typedef struct packed {
    data_t data;
    logic  last;
  } matrix_data_t;

  typedef matrix_data_t [SYS_ARRAY_SIZE-1:0] lane_vec_t;

  typedef enum logic [1:0] {
    FEED_IDLE,
    FEED_RUN,
    FEED_FLUSH
  } feeder_state_t;

endpackage

// File: rtl/operand_skew_feeder_if.sv
// Row input handshake plus skewed lane outputs between the operand reader and one array edge.
interface operand_skew_feeder_if #(
  parameter int N          = operand_skew_feeder_pkg::SYS_ARRAY_SIZE,
  parameter int DATA_WIDTH = operand_skew_feeder_pkg::DATA_WIDTH
);
  import operand_skew_feeder_pkg::*;

  logic                    start_i;
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic [N*DATA_WIDTH-1:0] in_data_i;
  matrix_data_t [N-1:0]    lane_o;
  logic [N-1:0]            lane_valid_o;
  logic                    busy_o;
  logic                    done_o;

  modport master (
    output start_i, in_valid_i, in_data_i,
    input  in_ready_o, lane_o, lane_valid_o, busy_o, done_o
  );

  modport slave (
    input  start_i, in_valid_i, in_data_i,
    output in_ready_o, lane_o, lane_valid_o, busy_o, done_o
  );
endinterface

// File: rtl/operand_skew_feeder_skew_delay_line.sv
// Fixed-depth register chain for one lane; DEPTH=0 collapses to a wire.
module skew_delay_line
  import operand_skew_feeder_pkg::*;
#(
  parameter int DEPTH = SKEW_DEPTH
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  input  matrix_data_t in_data_i,
  output logic         out_valid_o,
  output matrix_data_t out_data_o
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign out_valid_o = in_valid_i;
      assign out_data_o  = in_data_i;
    end else begin : g_chain
      logic [DEPTH-1:0]         valid_q;
      matrix_data_t [DEPTH-1:0] data_q;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          valid_q <= '0;
          data_q  <= '0;
        end else begin
          valid_q[0] <= in_valid_i;
          data_q[0]  <= in_data_i;
          for (int k = 1; k < DEPTH; k++) begin
            valid_q[k] <= valid_q[k-1];
            data_q[k]  <= data_q[k-1];
          end
        end
      end

      assign out_valid_o = valid_q[DEPTH-1];
      assign out_data_o  = data_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/operand_skew_feeder.sv
// Accepts ROWS operand rows and re-emits them as N lanes, lane i lagging lane 0 by i cycles.
module operand_skew_feeder #(
  parameter int N          = operand_skew_feeder_pkg::SYS_ARRAY_SIZE,
  parameter int ROWS       = operand_skew_feeder_pkg::T_C,
  parameter int DATA_WIDTH = operand_skew_feeder_pkg::DATA_WIDTH
) (
  input logic                  clk_i,
  input logic                  rst_i,
  operand_skew_feeder_if.slave bus
);
  import operand_skew_feeder_pkg::*;

  localparam int ROW_W   = clog2_min1(ROWS);
  localparam int FLUSH_W = clog2_min1(N);

  typedef logic [ROW_W-1:0]   row_cnt_t;
  typedef logic [FLUSH_W-1:0] flush_cnt_t;

  localparam row_cnt_t   LAST_ROW   = row_cnt_t'(ROWS - 1);
  localparam flush_cnt_t LAST_FLUSH = flush_cnt_t'(N - 1);

  feeder_state_t        state;
  row_cnt_t             row_cnt;
  flush_cnt_t           flush_cnt;
  logic                 busy_q;
  logic                 done_q;
  logic                 accept;
  logic                 last_row;
  logic                 stage_v;
  matrix_data_t [N-1:0] stage_d;
  logic [N-1:0]         lane_v;
  matrix_data_t [N-1:0] lane_d;

  assign accept   = bus.in_valid_i && (state == FEED_RUN);
  assign last_row = accept && (row_cnt == LAST_ROW);

  // done is registered one step early so it lines up with lane N-1 showing last
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= FEED_IDLE;
      row_cnt   <= '0;
      flush_cnt <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state)
        FEED_IDLE: begin
          done_q <= 1'b0;
          if (bus.start_i) begin
            state   <= FEED_RUN;
            row_cnt <= '0;
            busy_q  <= 1'b1;
          end
        end
        FEED_RUN: begin
          if (last_row) begin
            state     <= FEED_FLUSH;
            flush_cnt <= '0;
            done_q    <= (N == 1);
          end else if (accept) begin
            row_cnt <= row_cnt + row_cnt_t'(1);
          end
        end
        FEED_FLUSH: begin
          if (flush_cnt == LAST_FLUSH) begin
            state     <= FEED_IDLE;
            flush_cnt <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt + flush_cnt_t'(1);
            done_q    <= ((flush_cnt + flush_cnt_t'(1)) == LAST_FLUSH);
          end
        end
        default: state <= FEED_IDLE;
      endcase
    end
  end

  // Shared input register; a missed slot is loaded as an all-zero bubble
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_v <= 1'b0;
      stage_d <= '0;
    end else begin
      stage_v <= accept;
      for (int i = 0; i < N; i++) begin
        stage_d[i].data <= accept ? bus.in_data_i[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        stage_d[i].last <= last_row;
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    skew_delay_line #(
      .DEPTH(g)
    ) u_line (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .in_valid_i (stage_v),
      .in_data_i  (stage_d[g]),
      .out_valid_o(lane_v[g]),
      .out_data_o (lane_d[g])
    );
  end

  assign bus.in_ready_o   = (state == FEED_RUN);
  assign bus.lane_valid_o = lane_v;
  assign bus.lane_o       = lane_d;
  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;

endmodule
